// File: rtl/uart_wb_master.sv
// uart_wb_master: serial command bridge acting as a single-transfer Wishbone classic master.
// Frames popped from the UART RX FIFO: cmd ('W' 0x57 / 'R' 0x52), ADDR_BYTES address bytes MSB
// first, then DATA_BYTES write-data bytes (writes only). Response pushed to the UART TX FIFO:
// status 'K' 0x4B or 'E' 0x45, followed by DATA_BYTES read-data bytes after a successful read.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rx_empty, rd_data, rd_uart      UART RX FIFO status/head byte and pop pulse
//   tx_full, w_data, wr_uart        UART TX FIFO status, byte and push pulse
//   wb_cyc_o .. wb_sel_o            Wishbone master request signals
//   wb_dat_i, wb_ack_i, wb_err_i    Wishbone slave response
//   busy                            FSM is not idle
//   bus_fault                       one-cycle pulse on slave error or bus timeout
module uart_wb_master #(
    parameter int unsigned ADDR_BYTES     = 4,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_SIZE   = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_empty,
    input  logic [7:0]                rd_data,
    output logic                      rd_uart,
    input  logic                      tx_full,
    output logic [7:0]                w_data,
    output logic                      wr_uart,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [8*ADDR_BYTES-1:0]   wb_adr_o,
    output logic [8*DATA_BYTES-1:0]   wb_dat_o,
    output logic [DATA_BYTES-1:0]     wb_sel_o,
    input  logic [8*DATA_BYTES-1:0]   wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    output logic                      busy,
    output logic                      bus_fault
);

    localparam int unsigned AW    = 8 * ADDR_BYTES;
    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] CMD_W  = 8'h57;
    localparam logic [7:0] CMD_R  = 8'h52;
    localparam logic [7:0] ST_OK  = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        SEND_STATUS,
        SEND_DATA
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [TIMEOUT_SIZE-1:0]   tmo_q, tmo_d;
    logic                      op_wr_q, op_wr_d;
    logic [7:0]                status_q, status_d;
    logic [DW-1:0]             rdat_q, rdat_d;

    logic                      rd_uart_d, wr_uart_d, cyc_d, stb_d, we_d, busy_d, fault_d;
    logic [7:0]                w_data_d;
    logic [AW-1:0]             adr_d;
    logic [DW-1:0]             dat_d;
    logic                      rx_take, tx_put, bus_done;

    // A byte is handled only when the previous pop/push pulse has cleared, so the FIFO head is fresh
    assign rx_take = !rx_empty && !rd_uart;
    assign tx_put  = !tx_full && !wr_uart;

    assign wb_sel_o = '1;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            op_wr_q   <= 1'b0;
            status_q  <= '0;
            rdat_q    <= '0;
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            w_data    <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            busy      <= 1'b0;
            bus_fault <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            op_wr_q   <= op_wr_d;
            status_q  <= status_d;
            rdat_q    <= rdat_d;
            rd_uart   <= rd_uart_d;
            wr_uart   <= wr_uart_d;
            w_data    <= w_data_d;
            wb_cyc_o  <= cyc_d;
            wb_stb_o  <= stb_d;
            wb_we_o   <= we_d;
            wb_adr_o  <= adr_d;
            wb_dat_o  <= dat_d;
            busy      <= busy_d;
            bus_fault <= fault_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        op_wr_d   = op_wr_q;
        status_d  = status_q;
        rdat_d    = rdat_q;
        rd_uart_d = 1'b0;
        wr_uart_d = 1'b0;
        w_data_d  = w_data;
        cyc_d     = wb_cyc_o;
        stb_d     = wb_stb_o;
        we_d      = wb_we_o;
        adr_d     = wb_adr_o;
        dat_d     = wb_dat_o;
        fault_d   = 1'b0;
        bus_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_take) begin
                    rd_uart_d = 1'b1;
                    cnt_d     = '0;
                    if (rd_data == CMD_W) begin
                        op_wr_d = 1'b1;
                        we_d    = 1'b1;
                        state_d = GET_ADDR;
                    end else if (rd_data == CMD_R) begin
                        op_wr_d = 1'b0;
                        we_d    = 1'b0;
                        state_d = GET_ADDR;
                    end
                end
            end

            GET_ADDR: begin
                if (rx_take) begin
                    rd_uart_d = 1'b1;
                    adr_d     = (wb_adr_o << 8) | AW'(rd_data);
                    if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
                        cnt_d = '0;
                        if (op_wr_q) begin
                            state_d = GET_DATA;
                        end else begin
                            state_d = BUS;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            tmo_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            GET_DATA: begin
                if (rx_take) begin
                    rd_uart_d = 1'b1;
                    dat_d     = (wb_dat_o << 8) | DW'(rd_data);
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            BUS: begin
                tmo_d = tmo_q + TIMEOUT_SIZE'(1);
                // err wins over ack, ack wins over timeout
                if (wb_err_i) begin
                    status_d = ST_ERR;
                    fault_d  = 1'b1;
                    bus_done = 1'b1;
                end else if (wb_ack_i) begin
                    if (!op_wr_q) begin
                        rdat_d = wb_dat_i;
                    end
                    status_d = ST_OK;
                    bus_done = 1'b1;
                end else if (tmo_q == TIMEOUT_SIZE'(TIMEOUT_CYCLES - 1)) begin
                    status_d = ST_ERR;
                    fault_d  = 1'b1;
                    bus_done = 1'b1;
                end
                if (bus_done) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = SEND_STATUS;
                end
            end

            SEND_STATUS: begin
                if (tx_put) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = status_q;
                    cnt_d     = '0;
                    state_d   = (status_q == ST_OK && !op_wr_q) ? SEND_DATA : IDLE;
                end
            end

            SEND_DATA: begin
                if (tx_put) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = rdat_q[DW-1 -: 8];
                    rdat_d    = rdat_q << 8;
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed bench for uart_wb_master with queue-modelled UART FIFOs and a
// configurable Wishbone slave (ack / err / both / silent after a chosen number of cycles).
module tb_uart_wb_master;

    logic        clk;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  rd_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;
    logic        bus_fault;

    uart_wb_master dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .rd_data   (rd_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .busy      (busy),
        .bus_fault (bus_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] popped;

    // slave: 0 silent, 1 ack, 2 err, 3 err+ack
    int          slv_mode  = 0;
    int          slv_delay = 1;
    int          cyc_cnt   = 0;
    int          cyc_len   = 0;
    int          last_cyc_len = 0;
    int          xact_count = 0;
    int          fault_count = 0;
    int          wr_count = 0;
    int          wr_while_full = 0;
    logic        last_we;
    logic [31:0] last_adr;
    logic [31:0] last_dat;
    logic [3:0]  last_sel;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO and slave models, all updated on the falling edge
    always @(negedge clk) begin
        if (rd_uart && rx_q.size() > 0) popped = rx_q.pop_front();
        if (wr_uart) begin
            wr_count++;
            if (tx_full) wr_while_full++;
            else tx_q.push_back(w_data);
        end
        if (bus_fault) fault_count++;
        rx_empty = (rx_q.size() == 0);
        rd_data  = rx_empty ? 8'h00 : rx_q[0];

        if (wb_ack_i || wb_err_i) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            cyc_cnt++;
            if (slv_mode != 0 && cyc_cnt == slv_delay) begin
                wb_ack_i = (slv_mode == 1 || slv_mode == 3);
                wb_err_i = (slv_mode == 2 || slv_mode == 3);
                last_we  = wb_we_o;
                last_adr = wb_adr_o;
                last_dat = wb_dat_o;
                last_sel = wb_sel_o;
                xact_count++;
            end
        end
        if (!wb_cyc_o) cyc_cnt = 0;

        if (wb_cyc_o) cyc_len++;
        else if (cyc_len != 0) begin
            last_cyc_len = cyc_len;
            cyc_len = 0;
        end
    end

    task automatic send(input int n, input logic [71:0] bytes);
        @(negedge clk);
        for (int i = 0; i < n; i++) rx_q.push_back(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic clear_stats();
        @(negedge clk);
        tx_q.delete();
        xact_count = 0;
        fault_count = 0;
        wr_count = 0;
        wr_while_full = 0;
        last_cyc_len = 0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (rx_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() != 0) check("rx_drain_timeout", 64'd1, 64'd0);
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("busy_timeout", 64'd1, 64'd0);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [63:0] tx_packed();
        logic [63:0] v;
        v = '0;
        foreach (tx_q[i]) v = (v << 8) | 64'(tx_q[i]);
        return v;
    endfunction

    initial begin
        reset    = 1'b1;
        tx_full  = 1'b0;
        rx_empty = 1'b1;
        rd_data  = 8'h00;
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_rd_uart", 64'(rd_uart), 64'd0);
        check("rst_wr_uart", 64'(wr_uart), 64'd0);
        check("rst_w_data", 64'(w_data), 64'd0);
        check("rst_cyc_stb_we", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_sel", 64'(wb_sel_o), 64'hF);
        check("rst_busy_fault", 64'({busy, bus_fault}), 64'd0);
        reset = 1'b0;

        // 1: write with ack after 3 clk
        clear_stats();
        slv_mode = 1; slv_delay = 3;
        send(9, 72'h57_00000010_DEADBEEF);
        wait_done();
        check("t1_xacts", 64'(xact_count), 64'd1);
        check("t1_we", 64'(last_we), 64'd1);
        check("t1_adr", 64'(last_adr), 64'h10);
        check("t1_dat", 64'(last_dat), 64'hDEADBEEF);
        check("t1_sel", 64'(last_sel), 64'hF);
        check("t1_cyc_len", 64'(last_cyc_len), 64'd3);
        check("t1_tx_n", 64'(tx_q.size()), 64'd1);
        check("t1_tx", tx_packed(), 64'h4B);
        check("t1_fault", 64'(fault_count), 64'd0);

        // 2: read returning 0x12345678
        clear_stats();
        slv_mode = 1; slv_delay = 1; wb_dat_i = 32'h12345678;
        send(5, 72'h52_00000020);
        wait_done();
        check("t2_we", 64'(last_we), 64'd0);
        check("t2_adr", 64'(last_adr), 64'h20);
        check("t2_tx_n", 64'(tx_q.size()), 64'd5);
        check("t2_tx", tx_packed(), 64'h4B_12345678);
        check("t2_busy", 64'(busy), 64'd0);

        // 3: read timeout
        clear_stats();
        slv_mode = 0;
        send(5, 72'h52_00000030);
        wait_done();
        check("t3_cyc_len", 64'(last_cyc_len), 64'd1024);
        check("t3_fault", 64'(fault_count), 64'd1);
        check("t3_tx_n", 64'(tx_q.size()), 64'd1);
        check("t3_tx", tx_packed(), 64'h45);

        // 4: err and ack together, then an unknown cmd byte
        clear_stats();
        slv_mode = 3; slv_delay = 2;
        send(5, 72'h52_00000040);
        wait_done();
        check("t4_tx_n", 64'(tx_q.size()), 64'd1);
        check("t4_tx", tx_packed(), 64'h45);
        check("t4_fault", 64'(fault_count), 64'd1);
        clear_stats();
        send(1, 72'h00);
        wait_done();
        check("t4_bad_popped", 64'(rx_q.size()), 64'd0);
        check("t4_bad_tx_n", 64'(tx_q.size()), 64'd0);
        check("t4_bad_busy", 64'(busy), 64'd0);
        check("t4_bad_cyc", 64'(last_cyc_len), 64'd0);

        // 5: tx_full stall during read response
        clear_stats();
        tx_full = 1'b1;
        slv_mode = 1; slv_delay = 1; wb_dat_i = 32'hA5C30F96;
        send(5, 72'h52_00000044);
        repeat (60) @(negedge clk);
        check("t5_stall_wr", 64'(wr_count), 64'd0);
        check("t5_stall_busy", 64'(busy), 64'd1);
        tx_full = 1'b0;
        wait_done();
        check("t5_wr_full", 64'(wr_while_full), 64'd0);
        check("t5_tx_n", 64'(tx_q.size()), 64'd5);
        check("t5_tx", tx_packed(), 64'h4B_A5C30F96);

        // 6a: reset in GET_DATA
        clear_stats();
        send(7, 72'h57_00000040_1122);
        begin
            int t;
            t = 0;
            while (rx_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        end
        repeat (4) @(negedge clk);
        check("t6a_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6a_busy", 64'(busy), 64'd0);
        check("t6a_we_adr", 64'({wb_we_o, wb_adr_o}), 64'd0);
        check("t6a_dat", 64'(wb_dat_o), 64'd0);
        reset = 1'b0;

        // 6b: reset in BUS
        slv_mode = 0;
        send(5, 72'h52_00000050);
        begin
            int t;
            t = 0;
            while (!wb_cyc_o && t < 200) begin @(negedge clk); t++; end
            if (!wb_cyc_o) check("t6b_cyc_timeout", 64'd1, 64'd0);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6b_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        check("t6b_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 6c: full frame after reset
        clear_stats();
        slv_mode = 1; slv_delay = 2;
        send(9, 72'h57_00000060_CAFEBABE);
        wait_done();
        check("t6c_adr", 64'(last_adr), 64'h60);
        check("t6c_dat", 64'(last_dat), 64'hCAFEBABE);
        check("t6c_we", 64'(last_we), 64'd1);
        check("t6c_tx", tx_packed(), 64'h4B);
        check("t6c_tx_n", 64'(tx_q.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
